wmem_loader: RTL and testbench
==============================

# wmem_loader

Upstream feeder for the weight memory. Accepts a byte-serial weight stream over a valid/ready handshake, packs `ROW_NUM` consecutive `DATA_WIDTH` words into one `ROW_WGT_WIDTH` row, and issues one write per row on the weight memory's write port (`wr_en` / `wr_addr` / `wr_data`). Rows go to consecutive addresses starting at a base address given at start. It is the only writer of the weight memory during a load; bias rows are loaded like any other row by choosing the address range.

## Interface
- `DATA_WIDTH`, 8, width of one streamed weight word
- `ROW_NUM`, 6, words packed per memory row
- `ADDR_WIDTH`, 7, weight memory address width
- `ROW_WGT_WIDTH`, `DATA_WIDTH*ROW_NUM`, packed row width
- `i_clk` in 1, single clock, all logic on rising edge
- `i_rst_n` in 1, reset, asynchronous, active-low
- `i_start` in 1, begin a load; sampled only in IDLE
- `i_base_addr` in `ADDR_WIDTH`, first row address; latched on accepted start
- `i_num_rows` in `ADDR_WIDTH`, rows to load; latched on accepted start
- `i_data_valid` in 1, stream word valid
- `i_data` in `DATA_WIDTH`, stream word
- `o_data_ready` out 1, loader accepts a word this cycle
- `o_wr_en` out 1, one-cycle row write strobe
- `o_wr_addr` out `ADDR_WIDTH`, row write address
- `o_wr_data` out `ROW_WGT_WIDTH`, packed row
- `o_busy` out 1, load in progress
- `o_done` out 1, one-cycle pulse at load completion

## Operation
- **FSM states:** IDLE, LOAD, FINISH.
- **IDLE → LOAD:** on `i_start=1` with `i_num_rows≠0`. Latch base address and row count; clear the word index and row index.
- **IDLE → FINISH:** on `i_start=1` with `i_num_rows=0`. No writes occur.
- **`i_start` outside IDLE:** ignored.
- **Handshake:** a word is accepted when `i_data_valid & o_data_ready`. `o_data_ready` = (state==LOAD), decoded from the state register only, with no combinational path from `i_data_valid`. Gaps in `i_data_valid` are allowed anywhere.
- **Packing:** word k of a row (k = 0..ROW_NUM-1, in arrival order) lands in bits `[k*DATA_WIDTH +: DATA_WIDTH]`, so word 0 occupies the LSBs.
- **Row write:** on acceptance of word ROW_NUM-1, the full row is registered into `o_wr_data` and `o_wr_addr = base + row_index` (mod 2^ADDR_WIDTH, wraps silently). `o_wr_en=1` for exactly the next cycle.
- **After a row write:** word index returns to 0 and row index increments.
- **LOAD → FINISH:** on acceptance of the final word of the final row.
- **FINISH → IDLE:** unconditional after one cycle. `o_done=1` (registered) in the cycle after FINISH.
- **`o_busy`:** high in LOAD and FINISH.
- **Held outputs:** `o_wr_data` and `o_wr_addr` keep their last values when `o_wr_en=0`.
- **Reset:** asserting `i_rst_n` at any time returns the FSM to IDLE and discards any partial row. Outputs on reset: `o_wr_en=0`, `o_wr_addr=0`, `o_wr_data=0`, `o_data_ready=0`, `o_busy=0`, `o_done=0`.

## Timing
- **Start:** `i_start` at edge t → LOAD and `o_data_ready=1` from cycle t+1.
- **Throughput:** one word per cycle sustained. Ready stays high across row boundaries, so there are no bubbles between rows.
- **Write latency:** last word of a row accepted at edge t → `o_wr_en=1` during cycle t+1.
- **Final row:** FINISH occupies cycle t+1, concurrent with its write strobe. `o_done=1` during cycle t+2 and `o_busy=0` from t+2.
- **Zero-row start:** start at t → FINISH at t+1, `o_done` at t+2, `o_wr_en` never asserted.
- **Minimum load:** ROW_NUM×rows + 2 cycles from start to done.

## Structure
- **Shared package `wmem_pkg`:** state enum (IDLE/LOAD/FINISH) and the default width constants (`DATA_WIDTH`, `ROW_NUM`, `ADDR_WIDTH`). The weight memory and its readers use the same package.
- **Sub-module `wmem_row_packer`:** word index counter plus row assembly register, exposing a `row_full` strobe and the packed row. The top level holds the FSM, the row/address counter and the output registers.

## Test plan
- **Basic load:** start with base=0, num_rows=1; stream 0x01..0x06 → one `o_wr_en` at addr 0 with data 0x060504030201, `o_done` two cycles after word 6, busy low afterwards.
- **Multi-row with gaps:** base=0, num_rows=4; 24 words 0x10..0x27 with random valid gaps → writes at addrs 0,1,2,3. Addr 3 data = 0x272625242322. Exactly 4 strobes.
- **Address wrap:** base=126, num_rows=3 → writes at 126, 127, 0.
- **Zero rows and start-while-busy:** num_rows=0 → `o_done` at start+2 with no write. A second `i_start` pulse mid-load is ignored: row count and address are unchanged.
- **Reset mid-row:** assert `i_rst_n=0` after 3 words of row 1 → all outputs go to their reset values. A following fresh load of 1 row writes only the new 6 words, with no stale bytes.
- **Back-to-back loads:** `i_start` asserted in the cycle `o_done` is high, valid held high throughout → second load begins the next cycle and both address ranges are written correctly.

Source files
------------

// File: rtl/wmem_pkg.sv
// Shared definitions for the weight memory, its loader and its readers.
package wmem_pkg;

  // Default geometry of the weight memory
  localparam int WMEM_DATA_WIDTH = 8;
  localparam int WMEM_ROW_NUM    = 6;
  localparam int WMEM_ADDR_WIDTH = 7;

  // Loader control states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_FINISH = 2'd2
  } wmem_state_e;

endpackage

// File: rtl/wmem_row_packer.sv
// Assembles ROW_NUM consecutive stream words into one packed row.
// Word k of a row lands in bits [k*DATA_WIDTH +: DATA_WIDTH].
// o_row_data already contains the word being accepted, so it is
// complete in the same cycle o_row_full fires.
module wmem_row_packer
  import wmem_pkg::*;
#(
  parameter int DATA_WIDTH    = WMEM_DATA_WIDTH,
  parameter int ROW_NUM       = WMEM_ROW_NUM,
  parameter int ROW_WGT_WIDTH = DATA_WIDTH * ROW_NUM
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clear,
  input  logic                     i_accept,
  input  logic [DATA_WIDTH-1:0]    i_data,
  output logic                     o_row_full,
  output logic [ROW_WGT_WIDTH-1:0] o_row_data
);

  localparam int IDX_W = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROW_NUM - 1);

  logic [IDX_W-1:0]         word_idx_p0;
  logic [ROW_WGT_WIDTH-1:0] row_asm_p0;

  assign o_row_full = i_accept && (word_idx_p0 == LAST_IDX);

  // Word index: control state, cleared on reset, on a new load and after each full row
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      word_idx_p0 <= '0;
    end else if (i_clear || o_row_full) begin
      word_idx_p0 <= '0;
    end else if (i_accept) begin
      word_idx_p0 <= word_idx_p0 + IDX_W'(1);
    end
  end

  // Row assembly: pure datapath, every slot is rewritten before a row is emitted
  always_ff @(posedge i_clk) begin
    if (i_accept) begin
      row_asm_p0[word_idx_p0*DATA_WIDTH +: DATA_WIDTH] <= i_data;
    end
  end

  // Merge the word being accepted into the partial row
  always_comb begin
    o_row_data = row_asm_p0;
    o_row_data[word_idx_p0*DATA_WIDTH +: DATA_WIDTH] = i_data;
  end

endmodule

// File: rtl/wmem_loader.sv
// Streams weight words into the weight memory one packed row at a time,
// writing rows to consecutive addresses from a base given at start.
module wmem_loader
  import wmem_pkg::*;
#(
  parameter int DATA_WIDTH    = WMEM_DATA_WIDTH,
  parameter int ROW_NUM       = WMEM_ROW_NUM,
  parameter int ADDR_WIDTH    = WMEM_ADDR_WIDTH,
  parameter int ROW_WGT_WIDTH = DATA_WIDTH * ROW_NUM
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic [ADDR_WIDTH-1:0]    i_base_addr,
  input  logic [ADDR_WIDTH-1:0]    i_num_rows,
  input  logic                     i_data_valid,
  input  logic [DATA_WIDTH-1:0]    i_data,
  output logic                     o_data_ready,
  output logic                     o_wr_en,
  output logic [ADDR_WIDTH-1:0]    o_wr_addr,
  output logic [ROW_WGT_WIDTH-1:0] o_wr_data,
  output logic                     o_busy,
  output logic                     o_done
);

  wmem_state_e state_q, state_d;

  logic                     load_start;
  logic                     accept;
  logic                     row_full;
  logic                     last_row;
  logic [ROW_WGT_WIDTH-1:0] row_data;

  logic [ADDR_WIDTH-1:0]    base_q;
  logic [ADDR_WIDTH-1:0]    rows_q;
  logic [ADDR_WIDTH-1:0]    row_idx_q;

  logic                     wr_en_p1;
  logic [ADDR_WIDTH-1:0]    wr_addr_p1;
  logic [ROW_WGT_WIDTH-1:0] wr_data_p1;
  logic                     done_p1;

  // Ready is a pure state decode so it never depends on i_data_valid
  assign o_data_ready = (state_q == ST_LOAD);
  assign accept       = i_data_valid && o_data_ready;
  assign last_row     = (row_idx_q == (rows_q - ADDR_WIDTH'(1)));
  assign o_busy       = (state_q == ST_LOAD) || (state_q == ST_FINISH);

  wmem_row_packer #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ROW_NUM       (ROW_NUM),
    .ROW_WGT_WIDTH (ROW_WGT_WIDTH)
  ) u_packer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (load_start),
    .i_accept   (accept),
    .i_data     (i_data),
    .o_row_full (row_full),
    .o_row_data (row_data)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; a zero-row start goes straight to FINISH with no writes
  always_comb begin
    state_d    = state_q;
    load_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          if (i_num_rows != '0) begin
            state_d    = ST_LOAD;
            load_start = 1'b1;
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_LOAD: begin
        if (row_full && last_row) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Load parameters and row counter, latched only on an accepted start
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      base_q    <= '0;
      rows_q    <= '0;
      row_idx_q <= '0;
    end else if (load_start) begin
      base_q    <= i_base_addr;
      rows_q    <= i_num_rows;
      row_idx_q <= '0;
    end else if (row_full) begin
      row_idx_q <= row_idx_q + ADDR_WIDTH'(1);
    end
  end

  // ---- stage p1: registered write port and completion pulse ----
  // Address and data hold their last values between strobes; the address wraps modulo 2^ADDR_WIDTH
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_en_p1   <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
      done_p1    <= 1'b0;
    end else begin
      wr_en_p1 <= row_full;
      done_p1  <= (state_q == ST_FINISH);
      if (row_full) begin
        wr_addr_p1 <= base_q + row_idx_q;
        wr_data_p1 <= row_data;
      end
    end
  end

  assign o_wr_en   = wr_en_p1;
  assign o_wr_addr = wr_addr_p1;
  assign o_wr_data = wr_data_p1;
  assign o_done    = done_p1;

endmodule

// File: tb/tb_wmem_loader.sv
// Directed bench for wmem_loader: reset, single/multi-row loads, address
// wrap, zero-row and ignored starts, reset mid-row, back-to-back loads.
module tb_wmem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [6:0]  base_addr;
  logic [6:0]  num_rows;
  logic        data_valid;
  logic [7:0]  data;
  logic        data_ready;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [47:0] wr_data;
  logic        busy;
  logic        done;

  int vecs = 0;
  int errs = 0;

  logic [6:0]  wq_addr[$];
  logic [47:0] wq_data[$];

  wmem_loader dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_base_addr  (base_addr),
    .i_num_rows   (num_rows),
    .i_data_valid (data_valid),
    .i_data       (data),
    .o_data_ready (data_ready),
    .o_wr_en      (wr_en),
    .o_wr_addr    (wr_addr),
    .o_wr_data    (wr_data),
    .o_busy       (busy),
    .o_done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write strobe, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [6:0] b, input logic [6:0] n);
    base_addr = b;
    num_rows  = n;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Present n words first, first+1, ...; optional random idle gaps before each word
  task automatic send_stream(input logic [7:0] first, input int n, input bit gaps, output bit ok);
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        data_valid = 1'b0;
        for (int j = 0; j < g; j++) tick();
      end
      data_valid = 1'b1;
      data       = first + 8'(i);
      for (int w = 0; w < 50 && !data_ready; w++) tick();
      if (!data_ready) begin
        ok = 1'b0;
        data_valid = 1'b0;
        return;
      end
      tick();
    end
    data_valid = 1'b0;
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (done) begin
        seen = 1'b1;
        return;
      end
      tick();
    end
  endtask

  function automatic logic [47:0] pack_row(input logic [7:0] first);
    logic [47:0] r;
    for (int k = 0; k < 6; k++) r[k*8 +: 8] = first + 8'(k);
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    vecs++; if (data_ready !== 1'b0) begin errs++; $display("FAIL reset_ready got=%b exp=0", data_ready); end
    vecs++; if (wr_en !== 1'b0) begin errs++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
    vecs++; if (wr_addr !== 7'd0) begin errs++; $display("FAIL reset_wr_addr got=%0d exp=0", wr_addr); end
    vecs++; if (wr_data !== 48'd0) begin errs++; $display("FAIL reset_wr_data got=%h exp=0", wr_data); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vecs++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done got=%b exp=0", done); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    wq_addr.delete(); wq_data.delete();
    pulse_start(7'd0, 7'd1);
    vecs++; if (data_ready !== 1'b1 || busy !== 1'b1) begin errs++; $display("FAIL basic_start ready=%b busy=%b exp=1,1", data_ready, busy); end
    send_stream(8'h01, 6, 1'b0, ok);
    vecs++; if (!ok) begin errs++; $display("FAIL basic_stream timeout got=0 exp=1"); end
    vecs++; if (wr_en !== 1'b1 || wr_addr !== 7'd0 || wr_data !== 48'h060504030201) begin
      errs++; $display("FAIL basic_write en=%b addr=%0d data=%h exp 1/0/060504030201", wr_en, wr_addr, wr_data); end
    vecs++; if (busy !== 1'b1 || done !== 1'b0 || data_ready !== 1'b0) begin
      errs++; $display("FAIL basic_finish busy=%b done=%b ready=%b exp 1/0/0", busy, done, data_ready); end
    tick();
    vecs++; if (done !== 1'b1 || busy !== 1'b0 || wr_en !== 1'b0) begin
      errs++; $display("FAIL basic_done done=%b busy=%b wr_en=%b exp 1/0/0", done, busy, wr_en); end
    vecs++; if (wr_data !== 48'h060504030201) begin errs++; $display("FAIL basic_hold got=%h exp=060504030201", wr_data); end
    tick();
    vecs++; if (done !== 1'b0) begin errs++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    vecs++; if (wq_addr.size() != 1) begin errs++; $display("FAIL basic_count got=%0d exp=1", wq_addr.size()); end
  endtask

  task automatic test_multi_gaps();
    bit ok, seen;
    wq_addr.delete(); wq_data.delete();
    pulse_start(7'd0, 7'd4);
    send_stream(8'h10, 24, 1'b1, ok);
    wait_done(seen);
    vecs++; if (!ok || !seen) begin errs++; $display("FAIL multi_timeout got=%b%b exp=11", ok, seen); end
    tick();
    vecs++; if (wq_addr.size() != 4) begin errs++; $display("FAIL multi_count got=%0d exp=4", wq_addr.size()); end
    else begin
      for (int r = 0; r < 4; r++) begin
        vecs++;
        if (wq_addr[r] !== 7'(r) || wq_data[r] !== pack_row(8'h10 + 8'(6*r))) begin
          errs++; $display("FAIL multi_row%0d addr=%0d data=%h exp %0d/%h", r, wq_addr[r], wq_data[r], r, pack_row(8'h10 + 8'(6*r)));
        end
      end
      vecs++; if (wq_data[3] !== 48'h272625242322) begin errs++; $display("FAIL multi_last got=%h exp=272625242322", wq_data[3]); end
    end
  endtask

  task automatic test_wrap();
    bit ok, seen;
    logic [6:0] exp_a[3];
    exp_a[0] = 7'd126; exp_a[1] = 7'd127; exp_a[2] = 7'd0;
    wq_addr.delete(); wq_data.delete();
    pulse_start(7'd126, 7'd3);
    send_stream(8'h30, 18, 1'b0, ok);
    wait_done(seen);
    vecs++; if (!ok || !seen) begin errs++; $display("FAIL wrap_timeout got=%b%b exp=11", ok, seen); end
    tick();
    vecs++; if (wq_addr.size() != 3) begin errs++; $display("FAIL wrap_count got=%0d exp=3", wq_addr.size()); end
    else begin
      for (int r = 0; r < 3; r++) begin
        vecs++;
        if (wq_addr[r] !== exp_a[r] || wq_data[r] !== pack_row(8'h30 + 8'(6*r))) begin
          errs++; $display("FAIL wrap_row%0d addr=%0d data=%h exp %0d/%h", r, wq_addr[r], wq_data[r], exp_a[r], pack_row(8'h30 + 8'(6*r)));
        end
      end
    end
  endtask

  task automatic test_zero_and_restart();
    bit ok1, ok2, seen;
    wq_addr.delete(); wq_data.delete();
    pulse_start(7'd9, 7'd0);
    vecs++; if (busy !== 1'b1 || done !== 1'b0 || data_ready !== 1'b0) begin
      errs++; $display("FAIL zero_finish busy=%b done=%b ready=%b exp 1/0/0", busy, done, data_ready); end
    tick();
    vecs++; if (done !== 1'b1 || busy !== 1'b0) begin errs++; $display("FAIL zero_done done=%b busy=%b exp 1/0", done, busy); end
    tick();
    vecs++; if (wq_addr.size() != 0) begin errs++; $display("FAIL zero_writes got=%0d exp=0", wq_addr.size()); end
    // second start mid-load must not relatch base or count
    pulse_start(7'd10, 7'd2);
    send_stream(8'h40, 3, 1'b0, ok1);
    pulse_start(7'd50, 7'd1);
    send_stream(8'h43, 9, 1'b0, ok2);
    wait_done(seen);
    vecs++; if (!ok1 || !ok2 || !seen) begin errs++; $display("FAIL restart_timeout got=%b%b%b exp=111", ok1, ok2, seen); end
    tick();
    vecs++; if (wq_addr.size() != 2) begin errs++; $display("FAIL restart_count got=%0d exp=2", wq_addr.size()); end
    else begin
      vecs++; if (wq_addr[0] !== 7'd10 || wq_data[0] !== 48'h454443424140) begin
        errs++; $display("FAIL restart_row0 addr=%0d data=%h exp 10/454443424140", wq_addr[0], wq_data[0]); end
      vecs++; if (wq_addr[1] !== 7'd11 || wq_data[1] !== 48'h4b4a49484746) begin
        errs++; $display("FAIL restart_row1 addr=%0d data=%h exp 11/4b4a49484746", wq_addr[1], wq_data[1]); end
    end
  endtask

  task automatic test_reset_mid_row();
    bit ok, seen;
    pulse_start(7'd20, 7'd2);
    send_stream(8'h60, 9, 1'b0, ok);
    vecs++; if (!ok) begin errs++; $display("FAIL rstmid_stream timeout got=0 exp=1"); end
    rst_n = 1'b0;
    #1;
    vecs++; if (wr_en !== 1'b0 || wr_addr !== 7'd0 || wr_data !== 48'd0) begin
      errs++; $display("FAIL rstmid_wport en=%b addr=%0d data=%h exp 0/0/0", wr_en, wr_addr, wr_data); end
    vecs++; if (data_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errs++; $display("FAIL rstmid_ctrl ready=%b busy=%b done=%b exp 0/0/0", data_ready, busy, done); end
    tick();
    rst_n = 1'b1;
    tick();
    wq_addr.delete(); wq_data.delete();
    pulse_start(7'd5, 7'd1);
    send_stream(8'hA1, 6, 1'b0, ok);
    wait_done(seen);
    vecs++; if (!ok || !seen) begin errs++; $display("FAIL rstmid_reload timeout got=%b%b exp=11", ok, seen); end
    tick();
    vecs++; if (wq_addr.size() != 1) begin errs++; $display("FAIL rstmid_count got=%0d exp=1", wq_addr.size()); end
    else begin
      vecs++; if (wq_addr[0] !== 7'd5 || wq_data[0] !== 48'hA6A5A4A3A2A1) begin
        errs++; $display("FAIL rstmid_row addr=%0d data=%h exp 5/a6a5a4a3a2a1", wq_addr[0], wq_data[0]); end
    end
  endtask

  task automatic test_back_to_back();
    int  dones;
    bit  was_ready, restart;
    logic [6:0]  exp_a[3];
    logic [47:0] exp_d[3];
    exp_a[0] = 7'd40; exp_a[1] = 7'd60; exp_a[2] = 7'd61;
    exp_d[0] = 48'h555453525150; exp_d[1] = 48'h5b5a59585756; exp_d[2] = 48'h61605f5e5d5c;
    wq_addr.delete(); wq_data.delete();
    data_valid = 1'b1;
    data       = 8'h50;
    pulse_start(7'd40, 7'd1);
    dones = 0;
    for (int c = 0; c < 200 && dones < 2; c++) begin
      was_ready = data_ready;
      restart   = 1'b0;
      if (done) begin
        dones++;
        if (dones == 1) begin
          start = 1'b1; base_addr = 7'd60; num_rows = 7'd2; restart = 1'b1;
        end
      end
      if (dones < 2) begin
        tick();
        start = 1'b0;
        if (was_ready) data = data + 8'd1;
        if (restart) begin
          vecs++; if (data_ready !== 1'b1) begin errs++; $display("FAIL b2b_restart ready=%b exp=1", data_ready); end
        end
      end
    end
    data_valid = 1'b0;
    vecs++; if (dones != 2) begin errs++; $display("FAIL b2b_done_count got=%0d exp=2", dones); end
    tick();
    vecs++; if (wq_addr.size() != 3) begin errs++; $display("FAIL b2b_count got=%0d exp=3", wq_addr.size()); end
    else begin
      for (int r = 0; r < 3; r++) begin
        vecs++;
        if (wq_addr[r] !== exp_a[r] || wq_data[r] !== exp_d[r]) begin
          errs++; $display("FAIL b2b_row%0d addr=%0d data=%h exp %0d/%h", r, wq_addr[r], wq_data[r], exp_a[r], exp_d[r]);
        end
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    base_addr  = '0;
    num_rows   = '0;
    data_valid = 1'b0;
    data       = '0;
    test_reset();
    test_basic();
    test_multi_gaps();
    test_wrap();
    test_zero_and_restart();
    test_reset_mid_row();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
